// File: rtl/uart_tx_fifo_if.sv
// Handshake bundle between the system writer, the byte FIFO/launcher and the UART transmitter.
// Signal names carry the FIFO's port direction suffixes so existing connections map one-to-one.
interface uart_tx_fifo_if #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic             wrEn_i;
  logic [WIDTH-1:0] data_i;
  logic             clrOvf_i;
  logic             txRdy_i;
  logic             txDone_i;
  logic             txEn_o;
  logic [WIDTH-1:0] txData_o;
  logic             full_o;
  logic             empty_o;
  logic [CW-1:0]    count_o;
  logic             overflow_o;
  logic             busy_o;

  modport master (
    output wrEn_i, data_i, clrOvf_i, txRdy_i, txDone_i,
    input  txEn_o, txData_o, full_o, empty_o, count_o, overflow_o, busy_o
  );

  modport slave (
    input  wrEn_i, data_i, clrOvf_i, txRdy_i, txDone_i,
    output txEn_o, txData_o, full_o, empty_o, count_o, overflow_o, busy_o
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a UART transmitter: buffers bursts from the system side and launches
// one frame at a time, paced by the transmitter's rdy/done handshake.
module uart_tx_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8
) (
  input  logic           clk_i,
  input  logic           rst_i,
  uart_tx_fifo_if.slave  bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    ACCEPT,
    DONE
  } state_e;

  state_e            state_q;
  logic [PW-1:0]     wr_q, wr_d;
  logic [PW-1:0]     rd_q, rd_d;
  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic              txEn_q;
  logic [WIDTH-1:0]  txData_q;
  logic              overflow_q;
  logic              full, empty, do_wr, do_drop, do_pop;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  always_comb begin
    full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    empty   = (wr_q == rd_q);
    do_wr   = bus.wrEn_i && !full;
    do_drop = bus.wrEn_i && full;
    do_pop  = (state_q == IDLE) && !empty && bus.txRdy_i;
    wr_d    = do_wr  ? wr_q + PW'(1) : wr_q;
    rd_d    = do_pop ? rd_q + PW'(1) : rd_q;
  end

  always_ff @(posedge clk_i) begin
    if (do_wr) begin
      mem_q[wr_q[AW-1:0]] <= bus.data_i;
    end
  end

  // A drop in the same cycle as a clear leaves the flag set.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_q       <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_q <= wr_d;
      if (do_drop) begin
        overflow_q <= 1'b1;
      end else if (bus.clrOvf_i) begin
        overflow_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= IDLE;
      rd_q     <= '0;
      txEn_q   <= 1'b0;
      txData_q <= '0;
    end else begin
      rd_q   <= rd_d;
      txEn_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (do_pop) begin
            txData_q <= mem_q[rd_q[AW-1:0]];
            txEn_q   <= 1'b1;
            state_q  <= LAUNCH;
          end
        end
        LAUNCH: begin
          state_q <= ACCEPT;
        end
        ACCEPT: begin
          if (!bus.txRdy_i) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          if (bus.txDone_i) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.txEn_o     = txEn_q;
  assign bus.txData_o   = txData_q;
  assign bus.full_o     = full;
  assign bus.empty_o    = empty;
  assign bus.count_o    = wr_q - rd_q;
  assign bus.overflow_o = overflow_q;
  assign bus.busy_o     = (state_q != IDLE);
endmodule
